// File: rtl/dual_priority_encoder_pipe_if.sv
// dual_priority_encoder_pipe_if
// Request/result bus for the pipelined dual priority encoder.
// master: the side that issues request vectors and consumes results.
// slave: the encoder itself.
interface dual_priority_encoder_pipe_if #(
   parameter int N     = 12,
   parameter int IDX_W = 4,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     req;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] first_idx;
   logic             first_vld;
   logic [IDX_W-1:0] second_idx;
   logic             second_vld;
   logic [N-1:0]     first_onehot;
   logic [CNT_W-1:0] req_cnt;

   modport master (
      output in_valid, req, out_ready,
      input  in_ready, out_valid, first_idx, first_vld, second_idx, second_vld,
             first_onehot, req_cnt
   );

   modport slave (
      input  in_valid, req, out_ready,
      output in_ready, out_valid, first_idx, first_vld, second_idx, second_vld,
             first_onehot, req_cnt
   );
endinterface

// File: rtl/dual_priority_encoder_pipe.sv
// dual_priority_encoder_pipe
// Two-stage pipelined dual priority encoder with valid/ready on both sides.
// Stage 1 registers the request vector and its winning index; stage 2 masks
// the winner out, finds the runner-up, and registers all results.
// Optional macro DPE_ROTATE_EN: rotating priority pointer instead of the
// fixed descending order (bit N-1 highest).
module dual_priority_encoder_pipe #(
   parameter int N     = 12,
   parameter int IDX_W = 4,
   parameter int CNT_W = 4
) (
   input logic                       clk,
   input logic                       reset,
   dual_priority_encoder_pipe_if.slave bus
);

   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

   // Search vec starting at index start, walking downward and wrapping from
   // 0 to N-1. Returns {found, index}; index is 0 when nothing is found.
   function automatic logic [IDX_W:0] find_from(input logic [N-1:0]     vec,
                                                input logic [IDX_W-1:0] start);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] pos_idx;
      int               pos;
      found = 1'b0;
      idx   = {IDX_W{1'b0}};
      for (int k = 0; k < N; k++) begin
         pos = int'(start) - k;
         if (pos < 32'sd0) begin
            pos = pos + N;
         end else begin
            pos = pos;
         end
         pos_idx = IDX_W'(pos);
         if (!found && vec[pos_idx]) begin
            found = 1'b1;
            idx   = pos_idx;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // Population count of a request vector.
   function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] vec);
      logic [CNT_W-1:0] c;
      logic [N-1:0]     v;
      c = {CNT_W{1'b0}};
      v = vec;
      for (int i = 0; i < N; i++) begin
         c = c + CNT_W'(v[0]);
         v = v >> 1;
      end
      return c;
   endfunction

   // One-hot decode of an index, gated by its valid flag.
   function automatic logic [N-1:0] onehot_of(input logic             vld,
                                              input logic [IDX_W-1:0] idx);
      logic [N-1:0] oh;
      if (vld) begin
         oh = {{(N-1){1'b0}}, 1'b1} << idx;
      end else begin
         oh = {N{1'b0}};
      end
      return oh;
   endfunction

   // Stage 1 state
   logic             s1_valid_r;
   logic [N-1:0]     s1_req_r;
   logic [IDX_W-1:0] s1_first_idx_r;
   logic             s1_first_vld_r;

   // Stage 2 / output state
   logic             out_valid_r;
   logic [IDX_W-1:0] first_idx_r;
   logic             first_vld_r;
   logic [IDX_W-1:0] second_idx_r;
   logic             second_vld_r;
   logic [N-1:0]     first_onehot_r;
   logic [CNT_W-1:0] req_cnt_r;

   // Combinational
   logic             s2_en_s;
   logic             in_ready_s;
   logic             in_fire_s;
   logic [IDX_W-1:0] s1_start_s;
   logic [IDX_W-1:0] s2_start_s;
   logic [IDX_W:0]   first_srch_s;
   logic [N-1:0]     s1_onehot_s;
   logic [N-1:0]     mask_s;
   logic [IDX_W:0]   second_srch_s;
   logic [CNT_W-1:0] cnt_s;

`ifdef DPE_ROTATE_EN
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] s1_start_r;

   // Rotating pointer: after each non-empty accepted vector, the slot just
   // below the winner becomes the new top priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= TOP_IDX;
      end else if (in_fire_s && first_srch_s[IDX_W]) begin
         ptr_r <= (first_srch_s[IDX_W-1:0] == {IDX_W{1'b0}}) ? TOP_IDX
                : first_srch_s[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
      end
   end

   // Remember the pointer used for the first search so the second search
   // on the same vector walks the same order.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_start_r <= TOP_IDX;
      end else if (in_fire_s) begin
         s1_start_r <= ptr_r;
      end
   end

   assign s1_start_s = ptr_r;
   assign s2_start_s = s1_start_r;
`else
   assign s1_start_s = TOP_IDX;
   assign s2_start_s = TOP_IDX;
`endif

   // Handshake control: stage 2 may load when empty or being drained; stage 1
   // may load when empty or moving into stage 2. Closed while in reset.
   always_comb begin
      s2_en_s = !out_valid_r || bus.out_ready;
      if (reset) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = !s1_valid_r || s2_en_s;
      end
      in_fire_s = bus.in_valid && in_ready_s;
   end

   // Stage-1 and stage-2 search datapath.
   always_comb begin
      first_srch_s  = find_from(bus.req, s1_start_s);
      s1_onehot_s   = onehot_of(s1_first_vld_r, s1_first_idx_r);
      mask_s        = s1_req_r & ~s1_onehot_s;
      second_srch_s = find_from(mask_s, s2_start_s);
      cnt_s         = popcount(s1_req_r);
   end

   // Stage 1: capture request and winning index on input transfer; empty out
   // when contents advance without a refill.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r     <= 1'b0;
         s1_req_r       <= {N{1'b0}};
         s1_first_idx_r <= {IDX_W{1'b0}};
         s1_first_vld_r <= 1'b0;
      end else if (in_fire_s) begin
         s1_valid_r     <= 1'b1;
         s1_req_r       <= bus.req;
         s1_first_idx_r <= first_srch_s[IDX_W-1:0];
         s1_first_vld_r <= first_srch_s[IDX_W];
      end else if (s2_en_s) begin
         s1_valid_r     <= 1'b0;
      end
   end

   // Stage 2: register all results when stage 1 advances; otherwise drop
   // out_valid once the previous result has been taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r    <= 1'b0;
         first_idx_r    <= {IDX_W{1'b0}};
         first_vld_r    <= 1'b0;
         second_idx_r   <= {IDX_W{1'b0}};
         second_vld_r   <= 1'b0;
         first_onehot_r <= {N{1'b0}};
         req_cnt_r      <= {CNT_W{1'b0}};
      end else if (s2_en_s && s1_valid_r) begin
         out_valid_r    <= 1'b1;
         first_idx_r    <= s1_first_idx_r;
         first_vld_r    <= s1_first_vld_r;
         second_idx_r   <= second_srch_s[IDX_W-1:0];
         second_vld_r   <= second_srch_s[IDX_W];
         first_onehot_r <= s1_onehot_s;
         req_cnt_r      <= cnt_s;
      end else if (s2_en_s) begin
         out_valid_r    <= 1'b0;
      end
   end

   assign bus.in_ready     = in_ready_s;
   assign bus.out_valid    = out_valid_r;
   assign bus.first_idx    = first_idx_r;
   assign bus.first_vld    = first_vld_r;
   assign bus.second_idx   = second_idx_r;
   assign bus.second_vld   = second_vld_r;
   assign bus.first_onehot = first_onehot_r;
   assign bus.req_cnt      = req_cnt_r;

endmodule

// File: tb/tb_dual_priority_encoder_pipe.sv
// tb_dual_priority_encoder_pipe
// Scoreboard bench: the driver pushes hand-computed expectations on each
// input transfer; an independent monitor pops and compares on each output
// transfer.
module tb_dual_priority_encoder_pipe;
   localparam int N     = 12;
   localparam int IDX_W = 4;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [IDX_W-1:0] fi;
      logic             fv;
      logic [IDX_W-1:0] si;
      logic             sv;
      logic [N-1:0]     oh;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   dual_priority_encoder_pipe_if #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus();

   dual_priority_encoder_pipe #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   function automatic exp_t mk(input int fi, input int fv, input int si, input int sv,
                               input logic [N-1:0] oh, input int cnt);
      exp_t e;
      e.fi  = IDX_W'(fi);
      e.fv  = fv[0];
      e.si  = IDX_W'(si);
      e.sv  = sv[0];
      e.oh  = oh;
      e.cnt = CNT_W'(cnt);
      return e;
   endfunction

   function automatic logic [31:0] snap();
      return 32'({bus.out_valid, bus.first_idx, bus.first_vld, bus.second_idx,
                  bus.second_vld, bus.first_onehot, bus.req_cnt});
   endfunction

   // Monitor: compare every output transfer against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("first_idx",    32'(bus.first_idx),    32'(e.fi));
               check("first_vld",    32'(bus.first_vld),    32'(e.fv));
               check("second_idx",   32'(bus.second_idx),   32'(e.si));
               check("second_vld",   32'(bus.second_vld),   32'(e.sv));
               check("first_onehot", 32'(bus.first_onehot), 32'(e.oh));
               check("req_cnt",      32'(bus.req_cnt),      32'(e.cnt));
            end
         end
      end
   end

   // Present one vector until accepted; push its expectation at the transfer.
   task automatic send(input logic [N-1:0] r, input exp_t e);
      bit done;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.req      = r;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.req      = '0;
      check("send_accepted", 32'(done), 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && exp_q.size() > 0; k++) @(negedge clk);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fi;
      int si;
      logic [N-1:0] ohv;
      logic [31:0]  held;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.req       = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",     32'(bus.in_ready),     32'd0);
      check("rst_out_valid",    32'(bus.out_valid),    32'd0);
      check("rst_first_idx",    32'(bus.first_idx),    32'd0);
      check("rst_first_vld",    32'(bus.first_vld),    32'd0);
      check("rst_second_idx",   32'(bus.second_idx),   32'd0);
      check("rst_second_vld",   32'(bus.second_vld),   32'd0);
      check("rst_first_onehot", 32'(bus.first_onehot), 32'd0);
      check("rst_req_cnt",      32'(bus.req_cnt),      32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

`ifndef DPE_ROTATE_EN
      // Empty vector and two-cycle latency.
      send(12'h000, mk(0, 0, 0, 0, 12'h000, 0));
      @(negedge clk);
      check("latency_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("latency_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back directed vectors.
      send(12'h024, mk(5,  1, 2, 1, 12'h020, 2));
      send(12'h800, mk(11, 1, 0, 0, 12'h800, 1));
      send(12'h555, mk(10, 1, 8, 1, 12'h400, 6));
      send(12'h001, mk(0,  1, 0, 0, 12'h001, 1));
      send(12'h0A0, mk(7,  1, 5, 1, 12'h080, 2));
      drain();

      // Backpressure: fill both stages, hold outputs, then release.
      bus.out_ready = 1'b0;
      send(12'h003, mk(1, 1, 0, 1, 12'h002, 2));
      send(12'h180, mk(8, 1, 7, 1, 12'h100, 2));
      bus.in_valid = 1'b1;
      bus.req      = 12'hFFF;
      @(negedge clk);
      check("stall_in_ready",   32'(bus.in_ready),   32'd0);
      check("stall_out_valid",  32'(bus.out_valid),  32'd1);
      check("stall_first_idx",  32'(bus.first_idx),  32'd1);
      check("stall_second_idx", 32'(bus.second_idx), 32'd0);
      held = snap();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_hold_outputs",  snap(),            held);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(12'hFFF, mk(11, 1, 10, 1, 12'h800, 12));
      drain();

      // Reset with two vectors in flight.
      bus.out_ready = 1'b0;
      send(12'h0A0, mk(7,  1, 5, 1, 12'h080, 2));
      send(12'h555, mk(10, 1, 8, 1, 12'h400, 6));
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(12'h010, mk(4, 1, 0, 0, 12'h010, 1));
      drain();
`endif

      // All-ones stream at full rate; rotates when the pointer is enabled.
      for (int i = 0; i < 13; i++) begin
`ifdef DPE_ROTATE_EN
         fi = (i < 12) ? 11 - i : 11;
         si = (i < 11) ? 10 - i : ((i == 11) ? 11 : 10);
`else
         fi = 11;
         si = 10;
`endif
         ohv = {{(N-1){1'b0}}, 1'b1} << fi;
         send(12'hFFF, mk(fi, 1, si, 1, ohv, 12));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
